auto_trade_engine: RTL

Parametrised successor to the single-pair auto-trader. Consumes a byte-serial command stream (candle records, account updates, history flush) from the host link, keeps a ring buffer of the last DEPTH candles, and computes a moving average sequentially. It tracks position state (flat/long/short) and emits one-cycle buy/sell/close pulses. It sits between the UART byte receiver and the order-output logic.

---
 rtl/auto_trade_engine.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/auto_trade_engine.sv
// auto_trade_engine: byte-serial candle/account parser with a DEPTH-deep close
// history, sequential moving average, and a flat/long/short position tracker
// that emits one-cycle buy/sell/close pulses.
module auto_trade_engine #(
    parameter int DEPTH       = 4,
    parameter int PRICE_BYTES = 3,
    parameter int TAKE_PROFIT = 25,
    parameter int STOP_LOSS   = 15,
    parameter int ALLOW_SHORT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       buy,
    output logic       sell,
    output logic       close,
    output logic [1:0] position,
    output logic       hist_full
);

    localparam int PRICE_W = 8 * PRICE_BYTES;
    localparam int AW      = $clog2(DEPTH);
    localparam int SUM_W   = PRICE_W + AW;
    localparam int CW      = AW + 1;
    localparam int FW      = (PRICE_BYTES > 1) ? $clog2(PRICE_BYTES) : 1;

    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0]     LAST_IDX = AW'(DEPTH - 1);
    localparam logic [FW-1:0]     BIF_LAST = FW'(PRICE_BYTES - 1);
    localparam logic signed [8:0] SL_LIM   = 9'(-STOP_LOSS);
    localparam logic signed [8:0] TP_LIM   = 9'(TAKE_PROFIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_SUM,
        S_EVAL,
        S_ACCT
    } state_t;

    typedef enum logic [1:0] {
        POS_FLAT  = 2'b00,
        POS_LONG  = 2'b01,
        POS_SHORT = 2'b10
    } pos_t;

    state_t              state;
    pos_t                pos_q;
    logic [PRICE_W-1:0]  closes [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [CW-1:0]       count;
    logic [PRICE_W-1:0]  prev_vol;
    logic [PRICE_W-1:0]  cur_vol;
    logic [PRICE_W-1:0]  vol_sh;
    logic [PRICE_W-1:0]  rec_open;
    logic [PRICE_W-1:0]  rec_close;
    logic [7:0]          rec_ts;
    logic [7:0]          last_sig_ts;
    logic                sig_valid;
    logic [2:0]          fld;       // 0 = timestamp, 1..5 = open/high/low/close/volume
    logic [FW-1:0]       bif;       // byte index within the current price field
    logic [AW-1:0]       sidx;
    logic [SUM_W-1:0]    sum;

    logic [PRICE_W-1:0]  vol_next;
    logic [CW-1:0]       count_next;
    logic                last_byte;
    logic [PRICE_W-1:0]  ma;
    logic                bull;
    logic                bear;
    logic                sig_ok;
    logic                do_buy;
    logic                do_sell;
    logic signed [8:0]   profit;
    logic                acct_hit;

    assign in_ready = (state == S_IDLE) || (state == S_RECV) || (state == S_ACCT);
    assign position = pos_q;

    // Field assembly, moving-average compare, signal and account decisions
    always_comb begin
        vol_next   = (vol_sh << 8) | PRICE_W'(in_data);
        count_next = (count == FULL_CNT) ? count : count + CW'(1);
        last_byte  = (fld == 3'd5) && (bif == BIF_LAST);
        ma         = PRICE_W'(sum >> AW);
        bull       = (rec_close > ma) && (rec_close > rec_open) && (cur_vol > prev_vol);
        bear       = (rec_close < ma) && (rec_close < rec_open) && (cur_vol > prev_vol);
        sig_ok     = !sig_valid || (rec_ts != last_sig_ts);
        do_buy     = sig_ok && bull && ((pos_q == POS_FLAT) || (pos_q == POS_SHORT));
        do_sell    = sig_ok && bear && ((pos_q == POS_LONG) ||
                                        ((pos_q == POS_FLAT) && (ALLOW_SHORT != 0)));
        profit     = $signed({in_data[7], in_data});
        acct_hit   = (pos_q != POS_FLAT) && ((profit <= SL_LIM) || (profit >= TP_LIM));
    end

    // Command parser, history ring, MA accumulation and position FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pos_q       <= POS_FLAT;
            buy         <= 1'b0;
            sell        <= 1'b0;
            close       <= 1'b0;
            hist_full   <= 1'b0;
            wr_ptr      <= '0;
            count       <= '0;
            prev_vol    <= '0;
            cur_vol     <= '0;
            vol_sh      <= '0;
            rec_open    <= '0;
            rec_close   <= '0;
            rec_ts      <= '0;
            last_sig_ts <= '0;
            sig_valid   <= 1'b0;
            fld         <= '0;
            bif         <= '0;
            sidx        <= '0;
            sum         <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                closes[i] <= '0;
            end
        end else begin
            buy   <= 1'b0;
            sell  <= 1'b0;
            close <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        case (in_data)
                            8'h01: begin
                                state <= S_RECV;
                                fld   <= '0;
                                bif   <= '0;
                            end
                            8'h02: state <= S_ACCT;
                            8'h03: begin
                                count     <= '0;
                                wr_ptr    <= '0;
                                sig_valid <= 1'b0;
                                hist_full <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RECV: begin
                    if (in_valid) begin
                        if (fld == 3'd0) begin
                            rec_ts <= in_data;
                            fld    <= 3'd1;
                        end else begin
                            case (fld)
                                3'd1:    rec_open  <= (rec_open << 8) | PRICE_W'(in_data);
                                3'd4:    rec_close <= (rec_close << 8) | PRICE_W'(in_data);
                                3'd5:    vol_sh    <= vol_next;
                                default: ;  // high/low are not used by the strategy
                            endcase
                            if (bif == BIF_LAST) begin
                                bif <= '0;
                                fld <= fld + 3'd1;
                            end else begin
                                bif <= bif + FW'(1);
                            end
                            if (last_byte) begin
                                closes[wr_ptr] <= rec_close;
                                prev_vol       <= cur_vol;
                                cur_vol        <= vol_next;
                                wr_ptr         <= wr_ptr + AW'(1);
                                count          <= count_next;
                                hist_full      <= (count_next == FULL_CNT);
                                sum            <= '0;
                                sidx           <= '0;
                                state          <= (count_next == FULL_CNT) ? S_SUM : S_IDLE;
                            end
                        end
                    end
                end
                S_SUM: begin
                    sum  <= sum + SUM_W'(closes[sidx]);
                    sidx <= sidx + AW'(1);
                    if (sidx == LAST_IDX) begin
                        state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    buy  <= do_buy;
                    sell <= do_sell;
                    if (do_buy) begin
                        pos_q <= (pos_q == POS_FLAT) ? POS_LONG : POS_FLAT;
                    end
                    if (do_sell) begin
                        pos_q <= (pos_q == POS_FLAT) ? POS_SHORT : POS_FLAT;
                    end
                    if (do_buy || do_sell) begin
                        last_sig_ts <= rec_ts;
                        sig_valid   <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                S_ACCT: begin
                    if (in_valid) begin
                        if (acct_hit) begin
                            close <= 1'b1;
                            pos_q <= POS_FLAT;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
